// File: rtl/ahbsub_pkg.sv
// Purpose: shared types and bus constants for the AHB-Lite subordinate front-end.
// Latency: none (declarations only).
// Backpressure: not applicable.
package ahbsub_pkg;

   // Subordinate data-phase states
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_ERR1   = 2'd2,
      ST_ERR2   = 2'd3
   } state_t;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic HRESP_OKAY  = 1'b0;
   localparam logic HRESP_ERROR = 1'b1;

   // True when the transfer type carries a real transfer (NONSEQ/SEQ)
   function automatic logic transfer_active(input logic [1:0] htrans);
      logic act;
      case (htrans)
         HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
         HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
         default:                   act = 1'b0;
      endcase
      return act;
   endfunction

endpackage

// File: rtl/ahb_byte_en.sv
// Purpose: maps transfer size and low address bits to a byte-lane mask and misalignment flag.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module ahb_byte_en #(
   parameter  int DATA_W = 64,
   localparam int NB     = DATA_W / 8,
   localparam int LW     = $clog2(DATA_W / 8)
) (
   input  logic [2:0]    size,
   input  logic [LW-1:0] adr_lo,
   output logic [NB-1:0] byte_en,
   output logic          misaligned
);

   // Lane i is enabled when it falls inside [adr_lo, adr_lo + 2^size); lanes past NB drop off
   always_comb begin
      byte_en = '0;
      for (int i = 0; i < NB; i++) begin
         if ((i >= int'(adr_lo)) && ((i - int'(adr_lo)) < (1 << int'(size)))) begin
            byte_en[i] = 1'b1;
         end
      end
   end

   // Oversized transfers can never align; otherwise the low size bits of the address must be zero
   always_comb begin
      misaligned = (int'(size) > LW) ||
                   ((int'(adr_lo) & ((1 << int'(size)) - 1)) != 0);
   end

endmodule

// File: rtl/ahb_subordinate_fsm.sv
// Purpose: AHB-Lite subordinate front-end turning single transfers into req/ack back-end requests.
// Latency: one data-phase cycle minimum, plus one wait state per cycle without MemAck.
// Backpressure: HREADYOUT held low until MemAck; AHBSUB_ALIGN_CHECK_EN adds a two-cycle ERROR for misaligned transfers.
module ahb_subordinate_fsm
   import ahbsub_pkg::*;
#(
   parameter  int ADDR_W = 32,
   parameter  int DATA_W = 64,
   localparam int NB     = DATA_W / 8,
   localparam int LW     = $clog2(DATA_W / 8)
) (
   input  logic              HCLK,
   input  logic              HRESET,
   input  logic              HSEL,
   input  logic [ADDR_W-1:0] HADDR,
   input  logic [1:0]        HTRANS,
   input  logic              HWRITE,
   input  logic [2:0]        HSIZE,
   input  logic [DATA_W-1:0] HWDATA,
   input  logic              HREADY,
   output logic              HREADYOUT,
   output logic              HRESP,
   output logic [DATA_W-1:0] HRDATA,
   output logic              MemReq,
   output logic              MemWrite,
   output logic [ADDR_W-1:0] MemAdr,
   output logic [NB-1:0]     MemByteEn,
   output logic [DATA_W-1:0] MemWData,
   input  logic              MemAck,
   input  logic [DATA_W-1:0] MemRData
);

   state_t            state;
   state_t            state_nxt;
   state_t            access_tgt;
   logic              accept;
   logic              load;
   logic [ADDR_W-1:0] adr_q;
   logic [2:0]        size_q;
   logic              write_q;
   logic              lane_misaligned_unused;

   assign accept = HSEL && transfer_active(HTRANS) && HREADY;

   // Lane mask for the transfer currently in its data phase
   ahb_byte_en #(.DATA_W(DATA_W)) u_lane (
      .size       (size_q),
      .adr_lo     (adr_q[LW-1:0]),
      .byte_en    (MemByteEn),
      .misaligned (lane_misaligned_unused)
   );

`ifdef AHBSUB_ALIGN_CHECK_EN
   logic          req_misaligned;
   logic [NB-1:0] chk_byte_en_unused;

   // Alignment of the transfer being offered in the address phase
   ahb_byte_en #(.DATA_W(DATA_W)) u_chk (
      .size       (HSIZE),
      .adr_lo     (HADDR[LW-1:0]),
      .byte_en    (chk_byte_en_unused),
      .misaligned (req_misaligned)
   );

   assign access_tgt = req_misaligned ? ST_ERR1 : ST_ACCESS;
`else
   assign access_tgt = ST_ACCESS;
`endif

   // State register
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state and address-phase capture decision
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               state_nxt = access_tgt;
               load      = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (MemAck) begin
               if (accept) begin
                  state_nxt = access_tgt;
                  load      = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
            end
         end
`ifdef AHBSUB_ALIGN_CHECK_EN
         ST_ERR1: begin
            state_nxt = ST_ERR2;
         end
         ST_ERR2: begin
            if (accept) begin
               state_nxt = access_tgt;
               load      = 1'b1;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
`endif
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
   end

   // Address-phase registers; frozen while a request waits for MemAck
   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         adr_q   <= '0;
         size_q  <= '0;
         write_q <= 1'b0;
      end else if (load) begin
         adr_q   <= HADDR;
         size_q  <= HSIZE;
         write_q <= HWRITE;
      end
   end

   // Bus and back-end outputs decoded from the current state
   always_comb begin
      HREADYOUT = 1'b1;
      MemReq    = 1'b0;
      HRDATA    = '0;
      case (state)
         ST_IDLE: begin
            HREADYOUT = 1'b1;
         end
         ST_ACCESS: begin
            MemReq    = 1'b1;
            HREADYOUT = MemAck;
            if (MemAck && !write_q) begin
               HRDATA = MemRData;
            end
         end
         ST_ERR1: begin
            HREADYOUT = 1'b0;
         end
         ST_ERR2: begin
            HREADYOUT = 1'b1;
         end
         default: begin
            HREADYOUT = 1'b1;
         end
      endcase
`ifdef AHBSUB_ALIGN_CHECK_EN
      HRESP = ((state == ST_ERR1) || (state == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
      HRESP = HRESP_OKAY;
`endif
   end

   assign MemWrite = write_q;
   assign MemAdr   = adr_q;
   assign MemWData = HWDATA;

endmodule

// File: tb/tb_ahb_subordinate_fsm.sv
// Purpose: directed and randomized checks of the AHB-Lite subordinate front-end.
// Latency: not applicable.
// Backpressure: the bus HREADY is looped back from the single subordinate's HREADYOUT.
module tb_ahb_subordinate_fsm;

   logic        HCLK = 1'b0;
   logic        HRESET;
   logic        HSEL;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE;
   logic [63:0] HWDATA;
   logic        HREADY;
   logic        HREADYOUT;
   logic        HRESP;
   logic [63:0] HRDATA;
   logic        MemReq;
   logic        MemWrite;
   logic [31:0] MemAdr;
   logic [7:0]  MemByteEn;
   logic [63:0] MemWData;
   logic        MemAck;
   logic [63:0] MemRData;

   int checks = 0;
   int errors = 0;

   always #5 HCLK = ~HCLK;

   assign HREADY = HREADYOUT;

   ahb_subordinate_fsm #(.ADDR_W(32), .DATA_W(64)) dut (
      .HCLK      (HCLK),
      .HRESET    (HRESET),
      .HSEL      (HSEL),
      .HADDR     (HADDR),
      .HTRANS    (HTRANS),
      .HWRITE    (HWRITE),
      .HSIZE     (HSIZE),
      .HWDATA    (HWDATA),
      .HREADY    (HREADY),
      .HREADYOUT (HREADYOUT),
      .HRESP     (HRESP),
      .HRDATA    (HRDATA),
      .MemReq    (MemReq),
      .MemWrite  (MemWrite),
      .MemAdr    (MemAdr),
      .MemByteEn (MemByteEn),
      .MemWData  (MemWData),
      .MemAck    (MemAck),
      .MemRData  (MemRData)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance to 1 time unit after the next rising edge
   task automatic tick();
      @(posedge HCLK);
      #1;
   endtask

   task automatic bus_idle();
      HSEL   = 1'b0;
      HTRANS = 2'b00;
   endtask

   task automatic nonseq(input logic [31:0] a, input logic [2:0] sz, input logic wr);
      HSEL   = 1'b1;
      HTRANS = 2'b10;
      HADDR  = a;
      HSIZE  = sz;
      HWRITE = wr;
   endtask

   // Byte lanes a transfer touches: 2^size bytes starting at the lane offset, cut at 8 lanes
   function automatic logic [7:0] lanes(input logic [31:0] a, input int sz);
      logic [63:0] m;
      m = ((64'd1 << (1 << sz)) - 64'd1) << a[2:0];
      return m[7:0];
   endfunction

   function automatic bit is_misaligned(input logic [31:0] a, input int sz);
      return (sz > 3) || ((a % (32'd1 << sz)) != 0);
   endfunction

   task automatic zero_wait_read(input string tag);
      nonseq(32'h10, 3'd3, 1'b0);
      MemAck = 1'b0;
      #3;
      chk({tag, "_addr_rdy"}, HREADYOUT, 1);
      tick();
      bus_idle();
      MemAck   = 1'b1;
      MemRData = 64'hDEADBEEF_CAFEF00D;
      #3;
      chk({tag, "_req"},   MemReq, 1);
      chk({tag, "_adr"},   MemAdr, 32'h10);
      chk({tag, "_be"},    MemByteEn, 8'hFF);
      chk({tag, "_rdy"},   HREADYOUT, 1);
      chk({tag, "_rdata"}, HRDATA, 64'hDEADBEEF_CAFEF00D);
      chk({tag, "_wr"},    MemWrite, 0);
      tick();
      MemAck   = 1'b0;
      MemRData = '0;
      #3;
      chk({tag, "_req_drop"}, MemReq, 0);
      chk({tag, "_rdata0"},   HRDATA, 0);
      tick();
   endtask

   int          kind;      // 0 no data phase, 1 memory transfer, 2/3 first/second ERROR cycle
   logic [31:0] p_addr;
   int          p_size;
   logic        p_write;
   bit          exp_rdy, exp_req, exp_resp;
   logic [63:0] exp_rdata;
   bit          align_chk;
   bit          start;

   initial begin
`ifdef AHBSUB_ALIGN_CHECK_EN
      align_chk = 1'b1;
`else
      align_chk = 1'b0;
`endif
      HRESET   = 1'b1;
      HSEL     = 1'b0;
      HADDR    = '0;
      HTRANS   = 2'b00;
      HWRITE   = 1'b0;
      HSIZE    = '0;
      HWDATA   = '0;
      MemAck   = 1'b0;
      MemRData = '0;

      // Reset state
      #3;
      chk("rst_rdy",  HREADYOUT, 1);
      chk("rst_resp", HRESP, 0);
      chk("rst_req",  MemReq, 0);
      chk("rst_adr",  MemAdr, 0);
      chk("rst_wr",   MemWrite, 0);
      @(negedge HCLK);
      HRESET = 1'b0;
      tick();

      // Zero-wait read
      zero_wait_read("zw");

      // Byte write with three wait states
      nonseq(32'h13, 3'd0, 1'b1);
      tick();
      bus_idle();
      HWDATA = 64'h0000_0000_AB00_0000;
      MemAck = 1'b0;
      for (int w = 0; w < 3; w++) begin
         #3;
         chk("bw_wait_rdy", HREADYOUT, 0);
         chk("bw_wait_req", MemReq, 1);
         chk("bw_be",       MemByteEn, 8'h08);
         chk("bw_wdata",    MemWData, 64'h0000_0000_AB00_0000);
         chk("bw_wr",       MemWrite, 1);
         tick();
      end
      MemAck = 1'b1;
      #3;
      chk("bw_ack_rdy",   HREADYOUT, 1);
      chk("bw_ack_rdata", HRDATA, 0);
      tick();
      MemAck = 1'b0;
      #3;
      chk("bw_req_drop", MemReq, 0);
      tick();

      // Back-to-back read then write, second accepted on the ack cycle
      nonseq(32'h0, 3'd3, 1'b0);
      tick();
      nonseq(32'h8, 3'd3, 1'b1);
      MemAck   = 1'b1;
      MemRData = 64'h0123_4567_89AB_CDEF;
      #3;
      chk("b2b_req0",   MemReq, 1);
      chk("b2b_adr0",   MemAdr, 32'h0);
      chk("b2b_rdata0", HRDATA, 64'h0123_4567_89AB_CDEF);
      tick();
      bus_idle();
      HWDATA = 64'h5555_AAAA_5555_AAAA;
      #3;
      chk("b2b_req1", MemReq, 1);
      chk("b2b_adr1", MemAdr, 32'h8);
      chk("b2b_wr1",  MemWrite, 1);
      chk("b2b_rdy1", HREADYOUT, 1);
      tick();
      MemAck = 1'b0;
      #3;
      chk("b2b_req_drop", MemReq, 0);
      tick();

      // Misaligned word at 0x2
      nonseq(32'h2, 3'd2, 1'b0);
      tick();
      bus_idle();
      if (align_chk) begin
         MemAck = 1'b0;
         #3;
         chk("mis_e1_req",  MemReq, 0);
         chk("mis_e1_resp", HRESP, 1);
         chk("mis_e1_rdy",  HREADYOUT, 0);
         tick();
         #3;
         chk("mis_e2_req",  MemReq, 0);
         chk("mis_e2_resp", HRESP, 1);
         chk("mis_e2_rdy",  HREADYOUT, 1);
         tick();
         #3;
         chk("mis_done_resp", HRESP, 0);
         tick();
      end else begin
         MemAck = 1'b1;
         #3;
         chk("mis_req",  MemReq, 1);
         chk("mis_be",   MemByteEn, 8'h3C);
         chk("mis_resp", HRESP, 0);
         tick();
         MemAck = 1'b0;
      end

      // IDLE, BUSY and unselected NONSEQ produce no request
      for (int k = 0; k < 3; k++) begin
         HSEL   = (k < 2);
         HTRANS = (k == 0) ? 2'b00 : ((k == 1) ? 2'b01 : 2'b10);
         HADDR  = 32'h40;
         HSIZE  = 3'd3;
         HWRITE = 1'b0;
         tick();
         bus_idle();
         #3;
         chk("noxfer_req",  MemReq, 0);
         chk("noxfer_rdy",  HREADYOUT, 1);
         chk("noxfer_resp", HRESP, 0);
         tick();
      end

      // Reset asserted between edges while waiting for MemAck
      nonseq(32'h20, 3'd3, 1'b0);
      tick();
      bus_idle();
      MemAck = 1'b0;
      #3;
      chk("rmid_wait_rdy", HREADYOUT, 0);
      #2;
      HRESET = 1'b1;
      #1;
      chk("rmid_rdy", HREADYOUT, 1);
      chk("rmid_req", MemReq, 0);
      chk("rmid_adr", MemAdr, 0);
      #1;
      HRESET = 1'b0;
      tick();
      zero_wait_read("post_rst");

      // Randomized traffic against a transfer-level reference
      kind = 0;
      for (int c = 0; c < 600; c++) begin
         HSEL     = ($urandom_range(0, 3) != 0);
         HTRANS   = 2'($urandom_range(0, 3));
         HWRITE   = 1'($urandom_range(0, 1));
         HSIZE    = 3'($urandom_range(0, 4));
         HADDR    = $urandom & 32'h0000_00FF;
         HWDATA   = {$urandom, $urandom};
         MemAck   = ($urandom_range(0, 2) == 0);
         MemRData = {$urandom, $urandom};
         #3;
         exp_rdy   = 1'b1;
         exp_req   = 1'b0;
         exp_resp  = 1'b0;
         exp_rdata = '0;
         if (kind == 1) begin
            exp_req = 1'b1;
            exp_rdy = MemAck;
            if (MemAck && !p_write) exp_rdata = MemRData;
         end else if (kind == 2) begin
            exp_rdy  = 1'b0;
            exp_resp = 1'b1;
         end else if (kind == 3) begin
            exp_resp = 1'b1;
         end
         chk("rnd_rdy",   HREADYOUT, exp_rdy);
         chk("rnd_req",   MemReq, exp_req);
         chk("rnd_resp",  HRESP, exp_resp);
         chk("rnd_rdata", HRDATA, exp_rdata);
         chk("rnd_wdata", MemWData, HWDATA);
         if (kind == 1) begin
            chk("rnd_adr", MemAdr, p_addr);
            chk("rnd_be",  MemByteEn, lanes(p_addr, p_size));
            chk("rnd_wr",  MemWrite, p_write);
         end
         start = exp_rdy && HSEL && HTRANS[1];
         if (start) begin
            p_addr  = HADDR;
            p_size  = int'(HSIZE);
            p_write = HWRITE;
            kind    = (align_chk && is_misaligned(HADDR, int'(HSIZE))) ? 2 : 1;
         end else if (kind == 1 && MemAck) begin
            kind = 0;
         end else if (kind == 2) begin
            kind = 3;
         end else if (kind == 3) begin
            kind = 0;
         end
         tick();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
